// File: rtl/ysyx_22040759_mem_stage.sv
// Memory-access pipeline stage: latches the execute payload, runs the
// data-memory request/response handshake, aligns/extends load data and
// forwards the write-back payload.
// Optional feature macro: YSYX_22040759_MISALIGN_CHK_EN (misaligned accesses
// skip the memory request and are flagged on ms_misalign).
module ysyx_22040759_mem_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic         es_to_ms_valid,
   output logic         ms_allowin,
   input  logic [172:0] es_to_ms_bus,
   input  logic [63:0]  es_alu_result,
   input  logic         ws_allowin,
   output logic         ms_to_ws_valid,
   output logic [231:0] ms_to_ws_bus,
   output logic [63:0]  ms_fwd_result,
   output logic [4:0]   ms_rd,
   output logic         ms_reg_wen,
   output logic         dm_req_valid,
   input  logic         dm_req_ready,
   output logic         dm_req_wen,
   output logic [63:0]  dm_req_addr,
   output logic [63:0]  dm_req_wdata,
   output logic [7:0]   dm_req_wmask,
   input  logic         dm_rsp_valid,
   input  logic [63:0]  dm_rsp_rdata,
   output logic         ms_misalign
);

   localparam int unsigned XLEN     = 64;
   localparam int unsigned ES_BUS_W = 173;

`ifdef YSYX_22040759_MISALIGN_CHK_EN
   localparam bit MIS_CHK_EN = 1'b1;
`else
   localparam bit MIS_CHK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                ms_valid_q, ms_valid_d;
   logic [ES_BUS_W-1:0] bus_q, bus_d;
   logic [XLEN-1:0]     alu_q, alu_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;

   // Held payload fields
   logic [31:0]     f_inst;
   logic [XLEN-1:0] f_sdata;
   logic            f_mem_wen;
   logic            f_mem_ren;
   logic [2:0]      f_func3;
   logic [1:0]      f_wreg_sel;
   logic            f_reg_wen;
   logic [4:0]      f_rd;
   logic [XLEN-1:0] f_pc;
   logic [2:0]      off;

   assign f_inst     = bus_q[172:141];
   assign f_sdata    = bus_q[140:77];
   assign f_mem_wen  = bus_q[76];
   assign f_mem_ren  = bus_q[75];
   assign f_func3    = bus_q[74:72];
   assign f_wreg_sel = bus_q[71:70];
   assign f_reg_wen  = bus_q[69];
   assign f_rd       = bus_q[68:64];
   assign f_pc       = bus_q[63:0];
   assign off        = alu_q[2:0];

   // Access size (func3[1:0]) versus byte offset alignment
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] o);
      case (size)
         2'b01:   misaligned = o[0];
         2'b10:   misaligned = |o[1:0];
         2'b11:   misaligned = |o;
         default: misaligned = 1'b0;
      endcase
   endfunction

   logic in_mem, in_mis, held_mis, accept, ready_go;

   assign in_mem   = es_to_ms_bus[76] | es_to_ms_bus[75];
   assign in_mis   = MIS_CHK_EN & in_mem & misaligned(es_to_ms_bus[73:72], es_alu_result[2:0]);
   assign held_mis = MIS_CHK_EN & (f_mem_wen | f_mem_ren) & misaligned(f_func3[1:0], off);
   assign ready_go = (state_q == S_IDLE) | (state_q == S_DONE);
   assign ms_allowin = ~ms_valid_q | (ready_go & ws_allowin);
   assign accept   = es_to_ms_valid & ms_allowin;

   // Next-state: handshake, payload latch and memory FSM
   always_comb begin
      state_d    = state_q;
      ms_valid_d = ms_valid_q;
      bus_d      = bus_q;
      alu_d      = alu_q;
      rdata_d    = rdata_q;

      if (ms_allowin) ms_valid_d = es_to_ms_valid;
      if (accept) begin
         bus_d = es_to_ms_bus;
         alu_d = es_alu_result;
      end

      case (state_q)
         S_IDLE: begin
            if (accept && in_mem) state_d = in_mis ? S_DONE : S_REQ;
         end
         S_REQ: begin
            if (dm_req_ready) state_d = f_mem_wen ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            if (dm_rsp_valid) begin
               rdata_d = dm_rsp_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (ws_allowin) begin
               if (accept && in_mem) state_d = in_mis ? S_DONE : S_REQ;
               else                  state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and payload registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ms_valid_q <= 1'b0;
         bus_q      <= '0;
         alu_q      <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         ms_valid_q <= ms_valid_d;
         bus_q      <= bus_d;
         alu_q      <= alu_d;
         rdata_q    <= rdata_d;
      end
   end

   // Load alignment and sign/zero extension
   logic [XLEN-1:0] ld_shift, ld_ext, ld_field;
   assign ld_shift = rdata_q >> {off, 3'b000};

   always_comb begin
      ld_ext = '0;
      case (f_func3)
         3'b000:  ld_ext = {{56{ld_shift[7]}},  ld_shift[7:0]};
         3'b001:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
         3'b010:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
         3'b011:  ld_ext = ld_shift;
         3'b100:  ld_ext = {56'd0, ld_shift[7:0]};
         3'b101:  ld_ext = {48'd0, ld_shift[15:0]};
         3'b110:  ld_ext = {32'd0, ld_shift[31:0]};
         default: ld_ext = '0;
      endcase
   end

   assign ld_field = (f_mem_ren & ~held_mis) ? ld_ext : '0;

   // Byte-enable mask; bits shifted past lane 7 fall off
   logic [7:0] mask;
   always_comb begin
      mask = 8'h00;
      case (f_func3[1:0])
         2'b00:   mask = 8'h01 << off;
         2'b01:   mask = 8'h03 << off;
         2'b10:   mask = 8'h0F << off;
         default: mask = 8'hFF;
      endcase
   end

   // Output drive from held state
   assign ms_to_ws_valid = ms_valid_q & ready_go;
   assign ms_to_ws_bus   = {f_inst, ld_field, alu_q, f_wreg_sel,
                            f_reg_wen & ~held_mis, f_rd, f_pc};
   assign ms_fwd_result  = alu_q;
   assign ms_rd          = ms_valid_q ? f_rd : 5'd0;
   assign ms_reg_wen     = ms_valid_q & f_reg_wen;
   assign dm_req_valid   = (state_q == S_REQ);
   assign dm_req_wen     = f_mem_wen;
   assign dm_req_addr    = {alu_q[63:3], 3'b000};
   assign dm_req_wdata   = f_sdata << {off, 3'b000};
   assign dm_req_wmask   = (f_mem_wen | f_mem_ren) ? mask : 8'h00;
   assign ms_misalign    = ms_valid_q & (state_q == S_DONE) & held_mis;

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Self-checking bench for ysyx_22040759_mem_stage: directed vector table,
// randomized ops against a byte-level reference model, plus hand sequences
// for back-to-back, stall and reset corner cases.
module tb_ysyx_22040759_mem_stage;

   logic         clk, rst;
   logic         es_to_ms_valid, ms_allowin;
   logic [172:0] es_to_ms_bus;
   logic [63:0]  es_alu_result;
   logic         ws_allowin, ms_to_ws_valid;
   logic [231:0] ms_to_ws_bus;
   logic [63:0]  ms_fwd_result;
   logic [4:0]   ms_rd;
   logic         ms_reg_wen;
   logic         dm_req_valid, dm_req_ready, dm_req_wen;
   logic [63:0]  dm_req_addr, dm_req_wdata;
   logic [7:0]   dm_req_wmask;
   logic         dm_rsp_valid;
   logic [63:0]  dm_rsp_rdata;
   logic         ms_misalign;

   ysyx_22040759_mem_stage dut (
      .clk(clk), .rst(rst),
      .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
      .es_to_ms_bus(es_to_ms_bus), .es_alu_result(es_alu_result),
      .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
      .ms_to_ws_bus(ms_to_ws_bus), .ms_fwd_result(ms_fwd_result),
      .ms_rd(ms_rd), .ms_reg_wen(ms_reg_wen),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
      .dm_req_wen(dm_req_wen), .dm_req_addr(dm_req_addr),
      .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
      .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
      .ms_misalign(ms_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
      logic [4:0]  rd;
      logic        rwen;
      logic [1:0]  wsel;
      logic        ren, wen;
      logic [2:0]  f3;
      logic [63:0] sdata, alu, rdata;
      int          req_dly, rsp_dly, ws_dly;
      logic [63:0] e_ld;
      logic [7:0]  e_mask;
      logic [63:0] e_wdata;
   } vec_t;

   // Reference model: byte-by-byte view of the memory word
   function automatic logic [63:0] m_load(input logic [63:0] word, input int o, input logic [2:0] f3);
      int n;
      logic [63:0] v;
      if (f3 == 3'b111) return 64'd0;
      n = 1 << f3[1:0];
      v = 64'd0;
      for (int i = 0; i < n; i++)
         if (o + i < 8) v[8*i +: 8] = word[8*(o+i) +: 8];
      if (!f3[2] && n < 8 && v[8*n-1])
         for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] m_mask(input int o, input logic [2:0] f3);
      int n;
      logic [7:0] m;
      if (f3[1:0] == 2'b11) return 8'hFF;
      n = 1 << f3[1:0];
      m = 8'h00;
      for (int i = 0; i < n; i++)
         if (o + i < 8) m[o+i] = 1'b1;
      return m;
   endfunction

   function automatic logic m_mis(input int o, input logic [2:0] f3);
      int n;
      n = 1 << f3[1:0];
      return (n > 1) && ((o % n) != 0);
   endfunction

   function automatic vec_t mk(input logic [31:0] inst, input logic [63:0] pc, input logic [4:0] rd,
                               input logic rwen, input logic [1:0] wsel, input logic ren, input logic wen,
                               input logic [2:0] f3, input logic [63:0] sdata, input logic [63:0] alu,
                               input logic [63:0] rdata, input int rq, input int rs, input int ws,
                               input logic [63:0] e_ld, input logic [7:0] e_mask, input logic [63:0] e_wdata);
      vec_t v;
      v.inst = inst; v.pc = pc; v.rd = rd; v.rwen = rwen; v.wsel = wsel;
      v.ren = ren; v.wen = wen; v.f3 = f3; v.sdata = sdata; v.alu = alu; v.rdata = rdata;
      v.req_dly = rq; v.rsp_dly = rs; v.ws_dly = ws;
      v.e_ld = e_ld; v.e_mask = e_mask; v.e_wdata = e_wdata;
      return v;
   endfunction

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive one op into an empty stage and follow it to write-back
   task automatic run_op(input vec_t v);
      logic mem, mis;
      logic [231:0] exp_bus;
      mem = v.ren | v.wen;
      mis = 1'b0;
`ifdef YSYX_22040759_MISALIGN_CHK_EN
      mis = mem && m_mis(int'(v.alu[2:0]), v.f3);
`endif
      exp_bus = {v.inst, (v.ren && !mis) ? v.e_ld : 64'd0, v.alu, v.wsel,
                 v.rwen & ~mis, v.rd, v.pc};

      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = {v.inst, v.sdata, v.wen, v.ren, v.f3, v.wsel, v.rwen, v.rd, v.pc};
      es_alu_result  = v.alu;
      ws_allowin     = 1'b1;
      dm_req_ready   = 1'b0;
      dm_rsp_valid   = 1'b0;
      #1 chk("allowin_empty", ms_allowin, 1'b1);
      tick();
      es_to_ms_valid = 1'b0;
      es_to_ms_bus   = 173'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      es_alu_result  = r64();

      if (mem && !mis) begin
         for (int i = 0; i <= v.req_dly; i++) begin
            dm_req_ready = (i == v.req_dly);
            dm_rsp_valid = 1'($urandom);
            dm_rsp_rdata = r64();
            #1;
            chk("req_valid", dm_req_valid, 1'b1);
            chk("req_wen", dm_req_wen, v.wen);
            chk("req_addr", dm_req_addr, v.alu & ~64'h7);
            if (v.wen) begin
               chk("req_wmask", dm_req_wmask, v.e_mask);
               chk("req_wdata", dm_req_wdata, v.e_wdata);
            end
            chk("allowin_req", ms_allowin, 1'b0);
            chk("valid_req", ms_to_ws_valid, 1'b0);
            tick();
         end
         dm_req_ready = 1'b0;
         dm_rsp_valid = 1'b0;
         if (v.ren) begin
            for (int i = 0; i <= v.rsp_dly; i++) begin
               dm_rsp_valid = (i == v.rsp_dly);
               dm_rsp_rdata = (i == v.rsp_dly) ? v.rdata : r64();
               dm_req_ready = 1'($urandom);
               #1;
               chk("req_valid_wait", dm_req_valid, 1'b0);
               chk("valid_wait", ms_to_ws_valid, 1'b0);
               chk("allowin_wait", ms_allowin, 1'b0);
               tick();
            end
            dm_rsp_valid = 1'b0;
            dm_req_ready = 1'b0;
         end
      end

      for (int i = 0; i <= v.ws_dly; i++) begin
         ws_allowin   = (i == v.ws_dly);
         dm_rsp_valid = 1'($urandom);
         dm_rsp_rdata = r64();
         #1;
         chk("ws_valid", ms_to_ws_valid, 1'b1);
         chk("ws_bus", ms_to_ws_bus, exp_bus);
         chk("allowin_done", ms_allowin, ws_allowin);
         chk("ms_rd", ms_rd, v.rd);
         chk("ms_reg_wen", ms_reg_wen, v.rwen);
         chk("fwd", ms_fwd_result, v.alu);
         chk("misalign", ms_misalign, mis);
         chk("req_valid_done", dm_req_valid, 1'b0);
         tick();
      end
      ws_allowin   = 1'b1;
      dm_rsp_valid = 1'b0;
      #1;
      chk("drained_valid", ms_to_ws_valid, 1'b0);
      chk("drained_rd", ms_rd, 5'd0);
      chk("drained_reg_wen", ms_reg_wen, 1'b0);
   endtask

   vec_t tab[16];

   initial begin
      rst = 1'b1;
      es_to_ms_valid = 1'b0; es_to_ms_bus = '0; es_alu_result = '0;
      ws_allowin = 1'b1; dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_rdata = '0;

      tab[0]  = mk(32'h005302b3, 64'h80000000, 5'd5, 1, 2'd0, 0, 0, 3'd0, 64'd0, 64'h1234, 64'd0, 0, 0, 0,
                   64'd0, 8'h00, 64'd0);
      tab[1]  = mk(32'h00308283, 64'h80000004, 5'd5, 1, 2'd1, 1, 0, 3'd0, 64'd0, 64'h80000003,
                   64'h0000000080FF0000, 0, 0, 0, 64'hFFFFFFFFFFFFFF80, 8'h00, 64'd0);
      tab[2]  = mk(32'h00b11223, 64'h80000008, 5'd0, 0, 2'd0, 0, 1, 3'd1, 64'h000000000000ABCD, 64'h80000004,
                   64'd0, 1, 0, 0, 64'd0, 8'h30, 64'h0000ABCD00000000);
      tab[3]  = mk(32'h00215303, 64'h8000000c, 5'd6, 1, 2'd1, 1, 0, 3'd5, 64'd0, 64'h80000002,
                   64'h0000000080FF0000, 0, 1, 0, 64'h00000000000080FF, 8'h00, 64'd0);
      tab[4]  = mk(32'h00211383, 64'h80000010, 5'd7, 1, 2'd1, 1, 0, 3'd1, 64'd0, 64'h80000002,
                   64'h0000000080FF0000, 2, 0, 1, 64'hFFFFFFFFFFFF80FF, 8'h00, 64'd0);
      tab[5]  = mk(32'h00412403, 64'h80000014, 5'd8, 1, 2'd1, 1, 0, 3'd2, 64'd0, 64'h80000004,
                   64'h8765432100000000, 4, 2, 2, 64'hFFFFFFFF87654321, 8'h00, 64'd0);
      tab[6]  = mk(32'h00416483, 64'h80000018, 5'd9, 1, 2'd1, 1, 0, 3'd6, 64'd0, 64'h80000004,
                   64'h8765432100000000, 0, 0, 0, 64'h0000000087654321, 8'h00, 64'd0);
      tab[7]  = mk(32'h00813503, 64'h8000001c, 5'd10, 1, 2'd1, 1, 0, 3'd3, 64'd0, 64'h80000008,
                   64'h0123456789ABCDEF, 0, 0, 1, 64'h0123456789ABCDEF, 8'h00, 64'd0);
      tab[8]  = mk(32'h00017583, 64'h80000020, 5'd11, 1, 2'd1, 1, 0, 3'd7, 64'd0, 64'h80000000,
                   64'h1122334455667788, 0, 0, 0, 64'd0, 8'h00, 64'd0);
      tab[9]  = mk(32'h00c103a3, 64'h80000024, 5'd0, 0, 2'd0, 0, 1, 3'd0, 64'hFFFFFFFFFFFFFF5A, 64'h80000007,
                   64'd0, 0, 0, 0, 64'd0, 8'h80, 64'h5A00000000000000);
      tab[10] = mk(32'h00d12023, 64'h80000028, 5'd0, 0, 2'd0, 0, 1, 3'd2, 64'h00000000DEADBEEF, 64'h80000000,
                   64'd0, 2, 0, 0, 64'd0, 8'h0F, 64'h00000000DEADBEEF);
      tab[11] = mk(32'h00e13823, 64'h8000002c, 5'd0, 0, 2'd0, 0, 1, 3'd3, 64'h0123456789ABCDEF, 64'h80000010,
                   64'd0, 0, 0, 1, 64'd0, 8'hFF, 64'h0123456789ABCDEF);
      tab[12] = mk(32'h00114603, 64'h80000030, 5'd12, 1, 2'd1, 1, 0, 3'd4, 64'd0, 64'h80000001,
                   64'h000000000000C300, 0, 0, 0, 64'h00000000000000C3, 8'h00, 64'd0);
      tab[13] = mk(32'h00212683, 64'h80000034, 5'd13, 1, 2'd1, 1, 0, 3'd2, 64'd0, 64'h80000002,
                   64'h0000BEEF12340000, 0, 0, 0, 64'hFFFFFFFFBEEF1234, 8'h00, 64'd0);
      tab[14] = mk(32'h00f131a3, 64'h80000038, 5'd0, 0, 2'd0, 0, 1, 3'd3, 64'h1122334455667788, 64'h80000003,
                   64'd0, 0, 0, 0, 64'd0, 8'hFF, 64'h4455667788000000);
      tab[15] = mk(32'h00f12323, 64'h8000003c, 5'd0, 0, 2'd0, 0, 1, 3'd2, 64'h00000000AABBCCDD, 64'h80000006,
                   64'd0, 1, 0, 0, 64'd0, 8'hC0, 64'hCCDD000000000000);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", ms_to_ws_valid, 1'b0);
      chk("rst_allowin", ms_allowin, 1'b1);
      chk("rst_req_valid", dm_req_valid, 1'b0);
      chk("rst_misalign", ms_misalign, 1'b0);
      chk("rst_rd", ms_rd, 5'd0);
      chk("rst_reg_wen", ms_reg_wen, 1'b0);
      chk("rst_bus", ms_to_ws_bus, 232'd0);
      chk("rst_fwd", ms_fwd_result, 64'd0);
      chk("rst_wmask", dm_req_wmask, 8'h00);

      // Directed vectors
      for (int i = 0; i < 16; i++) run_op(tab[i]);

      // Randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         int kind, o;
         kind = int'($urandom_range(0, 2));
         v.inst = $urandom; v.pc = r64(); v.rd = 5'($urandom); v.rwen = 1'($urandom);
         v.wsel = 2'($urandom); v.sdata = r64(); v.alu = r64(); v.rdata = r64();
         v.ren = (kind == 1); v.wen = (kind == 2);
         v.f3 = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom);
         v.req_dly = int'($urandom_range(0, 2));
         v.rsp_dly = int'($urandom_range(0, 2));
         v.ws_dly  = int'($urandom_range(0, 2));
         o = int'(v.alu[2:0]);
         v.e_ld    = v.ren ? m_load(v.rdata, o, v.f3) : 64'd0;
         v.e_mask  = m_mask(o, v.f3);
         v.e_wdata = v.sdata << (8 * o);
         run_op(v);
      end

      // Back-to-back: store in DONE hands over to a new load the same cycle
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = {32'h1, 64'h55, 1'b1, 1'b0, 3'd3, 2'd0, 1'b0, 5'd0, 64'h100};
      es_alu_result = 64'h80000040;
      ws_allowin = 1'b1;
      tick();
      es_to_ms_valid = 1'b0;
      dm_req_ready = 1'b1;
      #1 chk("b2b_st_req", dm_req_valid, 1'b1);
      tick();
      dm_req_ready = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = {32'h2, 64'h0, 1'b0, 1'b1, 3'd3, 2'd1, 1'b1, 5'd3, 64'h104};
      es_alu_result = 64'h80000048;
      #1;
      chk("b2b_st_done", ms_to_ws_valid, 1'b1);
      chk("b2b_allowin", ms_allowin, 1'b1);
      tick();
      es_to_ms_valid = 1'b0;
      #1;
      chk("b2b_ld_req", dm_req_valid, 1'b1);
      chk("b2b_ld_wen", dm_req_wen, 1'b0);
      chk("b2b_ld_addr", dm_req_addr, 64'h80000048);
      chk("b2b_ld_valid", ms_to_ws_valid, 1'b0);
      dm_req_ready = 1'b1;
      tick();
      dm_req_ready = 1'b0;
      dm_rsp_valid = 1'b1;
      dm_rsp_rdata = 64'hCAFEF00D12345678;
      tick();
      dm_rsp_valid = 1'b0;
      #1;
      chk("b2b_ld_done", ms_to_ws_valid, 1'b1);
      chk("b2b_ld_data", ms_to_ws_bus[199:136], 64'hCAFEF00D12345678);
      tick();
      #1 chk("b2b_drained", ms_to_ws_valid, 1'b0);

      // Reset while waiting for a response, then a stray response
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = {32'h3, 64'h0, 1'b0, 1'b1, 3'd2, 2'd1, 1'b1, 5'd4, 64'h108};
      es_alu_result = 64'h80000050;
      tick();
      es_to_ms_valid = 1'b0;
      dm_req_ready = 1'b1;
      tick();
      dm_req_ready = 1'b0;
      #1 chk("rstw_in_wait", dm_req_valid, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dm_rsp_valid = 1'b1;
      dm_rsp_rdata = 64'hDEAD;
      #1;
      chk("rstw_valid", ms_to_ws_valid, 1'b0);
      chk("rstw_allowin", ms_allowin, 1'b1);
      chk("rstw_rd", ms_rd, 5'd0);
      repeat (2) begin
         tick();
         #1;
         chk("rstw_stray_valid", ms_to_ws_valid, 1'b0);
         chk("rstw_stray_req", dm_req_valid, 1'b0);
      end
      dm_rsp_valid = 1'b0;

      // Reset while a request is pending
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = {32'h4, 64'h77, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 5'd0, 64'h10c};
      es_alu_result = 64'h80000061;
      tick();
      es_to_ms_valid = 1'b0;
      #1 chk("rstr_req", dm_req_valid, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rstr_req_drop", dm_req_valid, 1'b0);
      chk("rstr_bus", ms_to_ws_bus, 232'd0);
      chk("rstr_fwd", ms_fwd_result, 64'd0);
      tick();
      #1 chk("rstr_idle", dm_req_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_22040759_mem_stage.md
# ysyx_22040759_mem_stage

Memory-access pipeline stage of the five-stage RV64 core; it is the receiving end of the execute-to-memory bus. It latches the execute payload plus the ALU result under the valid/allowin handshake and runs a data-memory request/response FSM for loads and stores. It aligns and extends load data, then forwards a write-back payload, forwarding value and hazard information.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; reset rst, synchronous, active-high.
- rst  in  1  synchronous reset, active-high.
- es_to_ms_valid  in  1  execute payload valid.
- ms_allowin  out  1  stage can accept a payload this cycle.
- es_to_ms_bus  in  173  payload fields:
  - [172:141] inst
  - [140:77] store data
  - [76] mem_wen
  - [75] mem_ren
  - [74:72] func3
  - [71:70] wreg_sel
  - [69] reg_wen
  - [68:64] rd
  - [63:0] pc
- es_alu_result  in  64  ALU result; this is the effective address for memory ops.
- ws_allowin  in  1  write-back stage can accept.
- ms_to_ws_valid  out  1  write-back payload valid.
- ms_to_ws_bus  out  232  payload fields:
  - [231:200] inst
  - [199:136] load data
  - [135:72] alu result
  - [71:70] wreg_sel
  - [69] reg_wen
  - [68:64] rd
  - [63:0] pc
- ms_fwd_result  out  64  latched ALU result, used for forwarding.
- ms_rd  out  5  destination register of the held instruction; 0 when the stage is not valid.
- ms_reg_wen  out  1  reg_wen of the held instruction, gated by valid.
- dm_req_valid  out  1  memory request valid.
- dm_req_ready  in  1  memory accepts the request.
- dm_req_wen  out  1  1 = store, 0 = load.
- dm_req_addr  out  64  effective address with [2:0] cleared.
- dm_req_wdata  out  64  store data shifted to its byte lane.
- dm_req_wmask  out  8  byte-enable mask.
- dm_rsp_valid  in  1  load response valid.
- dm_rsp_rdata  in  64  8-byte-aligned read data.
- ms_misalign  out  1  misaligned access flag (see Configuration).

## Operation
- Handshake:
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - On ms_allowin, ms_valid is loaded from es_to_ms_valid.
  - The bus and es_alu_result are latched only when es_to_ms_valid & ms_allowin.
  - ms_to_ws_valid = ms_valid & ms_ready_go.
- FSM states and transitions:
  - IDLE: stage is empty or holds a non-memory op.
  - On acceptance of an op with mem_ren|mem_wen, the next state is REQ.
  - REQ: dm_req_valid=1. On dm_req_ready, a store goes to DONE and a load goes to WAIT.
  - WAIT: dm_req_valid=0. On dm_rsp_valid, rdata is captured and the state goes to DONE.
  - DONE: when ws_allowin, go to REQ if a new memory op is accepted the same cycle, otherwise to IDLE.
- ms_ready_go:
  - 1 in IDLE while holding a non-memory op.
  - 1 in DONE.
  - 0 in REQ and WAIT.
- Byte offset: off = alu_result[2:0].
- Store encoding by func3:
  - 000 (SB): mask 8'h01<<off.
  - 001 (SH): mask 8'h03<<off.
  - 010 (SW): mask 8'h0F<<off.
  - 011 (SD): mask 8'hFF.
  - wdata = store_data << (8*off).
  - Mask bits shifted past bit 7 are dropped.
- Load encoding by func3; data is taken from rdata >> (8*off), then:
  - 000 (LB): sign-extend 8 bits.
  - 001 (LH): sign-extend 16 bits.
  - 010 (LW): sign-extend 32 bits.
  - 011 (LD): use all 64 bits.
  - 100 (LBU): zero-extend 8 bits.
  - 101 (LHU): zero-extend 16 bits.
  - 110 (LWU): zero-extend 32 bits.
  - Other func3 values: 0.
- Load-data field is 0 for non-load ops.

## Timing
- Reset values:
  - ms_valid=0, state IDLE.
  - ms_to_ws_valid=0, dm_req_valid=0, ms_misalign=0.
  - ms_rd=0, ms_reg_wen=0.
  - All registered payload bits = 0.
- Latency, counted from the acceptance edge:
  - Non-memory op: ms_to_ws_valid in the next cycle (1 cycle).
  - Store: earliest 2 cycles (REQ with ready high, then DONE).
  - Load: earliest 3 cycles (REQ, WAIT with rsp, then DONE).
- While dm_req_valid=1 and dm_req_ready=0, address, wdata, wmask and wen hold stable.
- A dm_rsp_valid arriving outside WAIT is ignored.
- rst asserted in REQ or WAIT: dm_req_valid drops the next cycle and any later response is ignored.
- ws_allowin=0 in DONE: the state, captured data and ms_to_ws_bus hold unchanged.

## Configuration
- YSYX_22040759_MISALIGN_CHK_EN defined:
  - An access is misaligned when it is H with off[0]!=0, W with off[1:0]!=0, or D with off!=0.
  - A misaligned op goes from acceptance directly to DONE with no request issued.
  - ms_misalign=1 while that op sits in DONE.
  - The op's reg_wen on ms_to_ws_bus is forced to 0 and its load data to 0.
- Not defined:
  - No check is made; truncated-mask behaviour applies.
  - ms_misalign is tied to 0.

## Test plan
- ADD result 0x1234, rd=5, ws_allowin=1 -> next cycle ms_to_ws_valid=1, bus[135:72]=0x1234, ms_rd=5, ms_reg_wen=1.
- LB at address 0x80000003 with rdata 0x00000000_80FF0000 -> dm_req_addr=0x80000000, load data=0xFFFF_FFFF_FFFF_FF80, valid 3 cycles after accept.
- SH at address 0x80000004 with data 0xABCD -> dm_req_wen=1, wmask=8'h30, wdata=0x0000ABCD_00000000, no response waited for.
- dm_req_ready low for 4 cycles, then rsp delayed 2 cycles, with ws_allowin=0 for 2 cycles in DONE -> request fields stable, ms_allowin=0 throughout, output held until ws_allowin.
- rst asserted while in WAIT, then a stray dm_rsp_valid -> state IDLE, ms_to_ws_valid stays 0.
- With the macro: LW at address 0x80000002 -> dm_req_valid never rises, ms_misalign=1, bus reg_wen=0. Without the macro: a request is issued with wmask/shift per off.
